// File: rtl/alu_rglr_pipe.sv
`default_nettype none
// ============================================================================
// Module   : alu_rglr_pipe
// Purpose  : Registered regular-ALU stage with a one-deep valid/ready output
//            register. Define SHIFT_ITER_EN for a 1-bit/cycle shifter.
// Revision : 1.0 - initial release
// ============================================================================
module alu_rglr_pipe #(
   parameter int XLEN    = 32,
   parameter int PC_SIZE = 32,
   parameter int TAG_W   = 5
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               alu_i_valid,
   output logic               alu_i_ready,
   input  logic [XLEN-1:0]    alu_i_rs1,
   input  logic [XLEN-1:0]    alu_i_rs2,
   input  logic [XLEN-1:0]    alu_i_imm,
   input  logic [PC_SIZE-1:0] alu_i_pc,
   input  logic [15:0]        alu_i_info,
   input  logic [TAG_W-1:0]   alu_i_tag,
   output logic               alu_o_valid,
   input  logic               alu_o_ready,
   output logic [XLEN-1:0]    alu_o_wbck_wdat,
   output logic               alu_o_wbck_en,
   output logic [TAG_W-1:0]   alu_o_tag
);

   localparam int SHAMT_W = $clog2(XLEN);

   logic               r_valid;
   logic [XLEN-1:0]    r_wdat;
   logic               r_wen;
   logic [TAG_W-1:0]   r_tag;

   logic [XLEN-1:0]    w_op1;
   logic [XLEN-1:0]    w_op2;
   logic [10:0]        w_ops;
   logic [10:0]        w_sel;
   logic               w_nop;
   logic [SHAMT_W-1:0] w_shamt;
   logic [XLEN-1:0]    w_res;
   logic               w_in_fire;
   logic               w_load;
   logic [1:0]         w_unused_info;

   assign w_unused_info = alu_i_info[1:0];

   always_comb begin
      w_op1 = '0;
      if (alu_i_info[14]) w_op1[PC_SIZE-1:0] = alu_i_pc;
      else                w_op1 = alu_i_rs1;
   end

   assign w_op2   = alu_i_info[13] ? alu_i_imm : alu_i_rs2;
   assign w_shamt = w_op2[SHAMT_W-1:0];

   // Isolating the lowest set op bit gives lowest-number-wins priority.
   assign w_ops = alu_i_info[12:2];
   assign w_sel = w_ops & (~w_ops + 11'd1);
   assign w_nop = alu_i_info[15] | ~(|w_ops);

   always_comb begin
      w_res = '0;
      if (!w_nop) begin
         if (w_sel[0])  w_res = w_op1 + w_op2;
         if (w_sel[1])  w_res = w_op1 - w_op2;
         if (w_sel[2])  w_res[0] = $signed(w_op1) < $signed(w_op2);
         if (w_sel[3])  w_res[0] = w_op1 < w_op2;
         if (w_sel[4])  w_res = w_op1 ^ w_op2;
         if (w_sel[5])  w_res = w_op1 | w_op2;
         if (w_sel[6])  w_res = w_op1 & w_op2;
         if (w_sel[7])  w_res = w_op1 << w_shamt;
         if (w_sel[8])  w_res = w_op1 >> w_shamt;
         if (w_sel[9])  w_res = $unsigned($signed(w_op1) >>> w_shamt);
         if (w_sel[10]) w_res = w_op2;
      end
   end

   assign w_in_fire = alu_i_valid & alu_i_ready;

`ifdef SHIFT_ITER_EN
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

   state_t             r_state;
   logic [XLEN-1:0]    r_work;
   logic [SHAMT_W-1:0] r_cnt;
   logic [TAG_W-1:0]   r_tag_it;
   logic [2:0]         r_shop;
   logic [XLEN-1:0]    w_work_nxt;
   logic               w_start_iter;
   logic               w_done_load;

   assign w_start_iter = w_in_fire & ~w_nop & (|w_sel[9:7]) & (w_shamt != '0);
   assign w_done_load  = (r_state == DONE) & (~r_valid | alu_o_ready);
   assign w_load       = w_in_fire & ~w_start_iter;
   assign alu_i_ready  = ~rst & (r_state == IDLE) & (~r_valid | alu_o_ready);

   always_comb begin
      w_work_nxt = {r_work[XLEN-1], r_work[XLEN-1:1]};
      if (r_shop[0]) w_work_nxt = {r_work[XLEN-2:0], 1'b0};
      if (r_shop[1]) w_work_nxt = {1'b0, r_work[XLEN-1:1]};
   end
`else
   assign w_load      = w_in_fire;
   assign alu_i_ready = ~rst & (~r_valid | alu_o_ready);
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         r_valid  <= 1'b0;
         r_wdat   <= '0;
         r_wen    <= 1'b0;
         r_tag    <= '0;
`ifdef SHIFT_ITER_EN
         r_state  <= IDLE;
         r_work   <= '0;
         r_cnt    <= '0;
         r_tag_it <= '0;
         r_shop   <= '0;
`endif
      end else begin
         if (w_load) begin
            r_valid <= 1'b1;
            r_wdat  <= w_res;
            r_wen   <= ~w_nop;
            r_tag   <= alu_i_tag;
         end
`ifdef SHIFT_ITER_EN
         else if (w_done_load) begin
            r_valid <= 1'b1;
            r_wdat  <= r_work;
            r_wen   <= 1'b1;
            r_tag   <= r_tag_it;
         end
`endif
         else if (alu_o_ready) begin
            r_valid <= 1'b0;
         end

`ifdef SHIFT_ITER_EN
         case (r_state)
            IDLE: begin
               if (w_start_iter) begin
                  r_state  <= SHIFT;
                  r_work   <= w_op1;
                  r_cnt    <= w_shamt;
                  r_tag_it <= alu_i_tag;
                  r_shop   <= w_sel[9:7];
               end
            end
            SHIFT: begin
               r_work <= w_work_nxt;
               r_cnt  <= r_cnt - SHAMT_W'(1);
               if (r_cnt == SHAMT_W'(1)) r_state <= DONE;
            end
            DONE: begin
               if (w_done_load) r_state <= IDLE;
            end
            default: r_state <= IDLE;
         endcase
`endif
      end
   end

   assign alu_o_valid     = r_valid;
   assign alu_o_wbck_wdat = r_wdat;
   assign alu_o_wbck_en   = r_wen;
   assign alu_o_tag       = r_tag;

endmodule
`default_nettype wire

// File: tb/tb_alu_rglr_pipe.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_rglr_pipe
// Purpose  : Scoreboard bench for alu_rglr_pipe (honours SHIFT_ITER_EN).
// Revision : 1.0 - initial release
// ============================================================================
module tb_alu_rglr_pipe;

   localparam logic [15:0] I_ADD = 16'h0004, I_SUB = 16'h0008, I_SLT = 16'h0010,
                           I_SLTU = 16'h0020, I_SLL = 16'h0200, I_SRA = 16'h0800,
                           I_LUI = 16'h1000, I_IMM = 16'h2000, I_PC = 16'h4000,
                           I_NOP = 16'h8000;
`ifdef SHIFT_ITER_EN
   localparam int SRA4_LAT = 6;
`else
   localparam int SRA4_LAT = 1;
`endif

   typedef struct packed {
      logic [31:0] wdat;
      logic        en;
      logic [4:0]  tag;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        alu_i_valid = 1'b0;
   logic        alu_i_ready;
   logic [31:0] alu_i_rs1 = '0, alu_i_rs2 = '0, alu_i_imm = '0, alu_i_pc = '0;
   logic [15:0] alu_i_info = '0;
   logic [4:0]  alu_i_tag = '0;
   logic        alu_o_valid;
   logic        alu_o_ready = 1'b1;
   logic [31:0] alu_o_wbck_wdat;
   logic        alu_o_wbck_en;
   logic [4:0]  alu_o_tag;

   int   n_checks = 0;
   int   n_fail   = 0;
   bit   rdy_rand = 1'b0;
   bit   rdy_force = 1'b1;
   exp_t sb[$];

   alu_rglr_pipe #(.XLEN(32), .PC_SIZE(32), .TAG_W(5)) dut (
      .clk(clk), .rst(rst),
      .alu_i_valid(alu_i_valid), .alu_i_ready(alu_i_ready),
      .alu_i_rs1(alu_i_rs1), .alu_i_rs2(alu_i_rs2), .alu_i_imm(alu_i_imm),
      .alu_i_pc(alu_i_pc), .alu_i_info(alu_i_info), .alu_i_tag(alu_i_tag),
      .alu_o_valid(alu_o_valid), .alu_o_ready(alu_o_ready),
      .alu_o_wbck_wdat(alu_o_wbck_wdat), .alu_o_wbck_en(alu_o_wbck_en),
      .alu_o_tag(alu_o_tag)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
      end
   endtask

   // Reference: evaluate the op from its architectural definition.
   function automatic exp_t model(input logic [15:0] info, input logic [31:0] rs1,
                                  input logic [31:0] rs2, input logic [31:0] imm,
                                  input logic [31:0] pc, input logic [4:0] tag);
      exp_t        r;
      logic [31:0] a, b;
      int          op, sh;
      a = info[14] ? pc : rs1;
      b = info[13] ? imm : rs2;
      r.tag = tag; r.en = 1'b0; r.wdat = '0;
      op = -1;
      for (int i = 12; i >= 2; i--) if (info[i]) op = i;
      if (info[15] || op < 0) return r;
      sh = int'(b % 32);
      r.en = 1'b1;
      case (op)
         2:  r.wdat = a + b;
         3:  r.wdat = a - b;
         4:  r.wdat = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
         5:  r.wdat = (a < b) ? 32'd1 : 32'd0;
         6:  r.wdat = a ^ b;
         7:  r.wdat = a | b;
         8:  r.wdat = a & b;
         9:  r.wdat = a << sh;
         10: r.wdat = a >> sh;
         11: r.wdat = a[31] ? ~((~a) >> sh) : (a >> sh);
         default: r.wdat = b;
      endcase
      return r;
   endfunction

   // Called at posedge+1; returns at posedge+1 after the accepting edge.
   task automatic send(input logic [15:0] info, input logic [31:0] rs1, input logic [31:0] rs2,
                       input logic [31:0] imm, input logic [31:0] pc, input logic [4:0] tag,
                       input exp_t e, input bit push);
      int w;
      alu_i_valid = 1'b1; alu_i_info = info; alu_i_rs1 = rs1; alu_i_rs2 = rs2;
      alu_i_imm = imm; alu_i_pc = pc; alu_i_tag = tag;
      w = 0;
      @(negedge clk);
      while (!alu_i_ready && w < 200) begin
         w++;
         @(negedge clk);
      end
      if (!alu_i_ready) chk("accept_timeout", {31'd0, alu_i_ready}, 32'd1);
      else if (push) sb.push_back(e);
      @(posedge clk); #1;
      alu_i_valid = 1'b0;
   endtask

   task automatic drain();
      int w;
      rdy_rand = 1'b0; rdy_force = 1'b1;
      w = 0;
      @(negedge clk);
      while ((sb.size() != 0 || alu_o_valid) && w < 300) begin
         w++;
         @(negedge clk);
      end
      chk("drain_queue_empty", sb.size(), 32'd0);
      @(posedge clk); #1;
   endtask

   task automatic lat_check(input string nm, input int exp_lat);
      int cnt;
      bit got;
      cnt = 0; got = 1'b0;
      while (cnt < 64 && !got) begin
         @(negedge clk);
         cnt++;
         if (alu_o_valid) got = 1'b1;
`ifdef SHIFT_ITER_EN
         else chk({nm, "_ready_busy"}, {31'd0, alu_i_ready}, 32'd0);
`endif
      end
      chk(nm, cnt, exp_lat);
      @(posedge clk); #1;
   endtask

   task automatic check_reset_outputs(input string nm);
      chk({nm, "_valid"}, {31'd0, alu_o_valid}, 32'd0);
      chk({nm, "_wdat"}, alu_o_wbck_wdat, 32'd0);
      chk({nm, "_en"}, {31'd0, alu_o_wbck_en}, 32'd0);
      chk({nm, "_tag"}, {27'd0, alu_o_tag}, 32'd0);
      chk({nm, "_iready"}, {31'd0, alu_i_ready}, 32'd0);
   endtask

   initial forever begin
      @(posedge clk); #1;
      alu_o_ready = rdy_rand ? ($urandom_range(0, 3) != 0) : rdy_force;
   end

   // Monitor: every delivered result must match the oldest outstanding expectation.
   initial forever begin
      @(negedge clk);
      if (!rst && alu_o_valid && alu_o_ready) begin
         if (sb.size() == 0) begin
            n_checks++; n_fail++;
            $display("FAIL unexpected_output: got wdat 0x%08h tag %0d, required none",
                     alu_o_wbck_wdat, alu_o_tag);
         end else begin
            exp_t e;
            e = sb.pop_front();
            chk("out_wdat", alu_o_wbck_wdat, e.wdat);
            chk("out_wbck_en", {31'd0, alu_o_wbck_en}, {31'd0, e.en});
            chk("out_tag", {27'd0, alu_o_tag}, {27'd0, e.tag});
         end
      end
   end

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      exp_t e;
      logic [15:0] info;
      logic [31:0] r1, r2, im, pc;
      bit   seen;

      repeat (3) @(posedge clk);
      @(negedge clk);
      check_reset_outputs("reset");
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      chk("ready_after_reset", {31'd0, alu_i_ready}, 32'd1);
      @(posedge clk); #1;

      e = '{32'h8000_0000, 1'b1, 5'd3};
      send(I_ADD, 32'h7FFF_FFFF, 32'd1, 32'd0, 32'd0, 5'd3, e, 1'b1);
      e = '{32'hFFFF_FFFF, 1'b1, 5'd4};
      send(I_SUB, 32'd0, 32'd1, 32'd0, 32'd0, 5'd4, e, 1'b1);
      e = '{32'd1, 1'b1, 5'd5};
      send(I_SLT, 32'hFFFF_FFFF, 32'd1, 32'd0, 32'd0, 5'd5, e, 1'b1);
      e = '{32'd0, 1'b1, 5'd6};
      send(I_SLTU, 32'hFFFF_FFFF, 32'd1, 32'd0, 32'd0, 5'd6, e, 1'b1);
      e = '{32'h0000_3000, 1'b1, 5'd7};
      send(I_ADD | I_PC | I_IMM, 32'h55, 32'h66, 32'h2000, 32'h1000, 5'd7, e, 1'b1);
      e = '{32'hABCD_E000, 1'b1, 5'd8};
      send(I_LUI | I_IMM, 32'h1, 32'h2, 32'hABCD_E000, 32'd0, 5'd8, e, 1'b1);
      e = '{32'd0, 1'b0, 5'd9};
      send(I_NOP | I_ADD, 32'd10, 32'd20, 32'd0, 32'd0, 5'd9, e, 1'b1);
      e = '{32'd0, 1'b0, 5'd10};
      send(16'h0003, 32'd10, 32'd20, 32'd0, 32'd0, 5'd10, e, 1'b1);
      e = '{32'd3, 1'b1, 5'd11};
      send(I_ADD | I_SUB | I_XOR_DUMMY(), 32'd1, 32'd2, 32'd0, 32'd0, 5'd11, e, 1'b1);
      drain();

      // Backpressure: tag 1 held, tag 2 waits, then both delivered in order.
      rdy_force = 1'b0;
      e = '{32'd11, 1'b1, 5'd1};
      send(I_ADD, 32'd5, 32'd6, 32'd0, 32'd0, 5'd1, e, 1'b1);
      alu_i_valid = 1'b1; alu_i_info = I_ADD; alu_i_rs1 = 32'd100; alu_i_rs2 = 32'd200;
      alu_i_tag = 5'd2;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         chk("bp_ready_low", {31'd0, alu_i_ready}, 32'd0);
         chk("bp_hold_valid", {31'd0, alu_o_valid}, 32'd1);
         chk("bp_hold_wdat", alu_o_wbck_wdat, 32'd11);
         chk("bp_hold_tag", {27'd0, alu_o_tag}, 32'd1);
      end
      rdy_force = 1'b1;
      @(posedge clk); #1;
      e = '{32'd300, 1'b1, 5'd2};
      send(I_ADD, 32'd100, 32'd200, 32'd0, 32'd0, 5'd2, e, 1'b1);
      drain();

      e = '{32'hF800_0000, 1'b1, 5'd12};
      send(I_SRA | I_IMM, 32'h8000_0000, 32'd0, 32'd4, 32'd0, 5'd12, e, 1'b1);
      lat_check("sra4_latency", SRA4_LAT);
      e = '{32'h0000_1234, 1'b1, 5'd13};
      send(I_SLL | I_IMM, 32'h0000_1234, 32'd0, 32'd0, 32'd0, 5'd13, e, 1'b1);
      lat_check("sll0_latency", 1);
      drain();

      // Reset discards a result held in the output register.
      rdy_force = 1'b0;
      send(I_ADD, 32'd1, 32'd2, 32'd0, 32'd0, 5'd7, e, 1'b0);
      @(negedge clk);
      chk("held_before_reset", {31'd0, alu_o_valid}, 32'd1);
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;
      check_reset_outputs("midreset");
      rst = 1'b0; rdy_force = 1'b1;
      @(negedge clk);
      chk("ready_after_midreset", {31'd0, alu_i_ready}, 32'd1);
      @(posedge clk); #1;

`ifdef SHIFT_ITER_EN
      // Reset aborts an in-flight iterative shift.
      send(I_SLL | I_IMM, 32'h0000_FFFF, 32'd0, 32'd31, 32'd0, 5'd15, e, 1'b0);
      repeat (3) @(posedge clk);
      #1 rst = 1'b1;
      @(posedge clk); #1;
      check_reset_outputs("abort");
      rst = 1'b0;
      @(negedge clk);
      chk("ready_after_abort", {31'd0, alu_i_ready}, 32'd1);
      seen = 1'b0;
      repeat (40) begin
         @(negedge clk);
         if (alu_o_valid) seen = 1'b1;
      end
      chk("abort_no_output", {31'd0, seen}, 32'd0);
      @(posedge clk); #1;
`endif

      rdy_rand = 1'b1;
      for (int n = 0; n < 300; n++) begin
         case ($urandom_range(0, 9))
            0:       info = 16'($urandom);
            1:       info = 16'($urandom) & 16'h6003;
            default: info = (16'h1 << $urandom_range(2, 12)) | (16'($urandom) & 16'h6003);
         endcase
         if ($urandom_range(0, 9) == 0) info = info | I_NOP;
         r1 = $urandom; r2 = $urandom; im = $urandom; pc = $urandom;
         if ($urandom_range(0, 3) == 0) r1 = {1'b1, 31'($urandom)};
         e = model(info, r1, r2, im, pc, 5'(n));
         send(info, r1, r2, im, pc, 5'(n), e, 1'b1);
         if ($urandom_range(0, 4) == 0) begin
            @(posedge clk); #1;
         end
      end
      drain();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   function automatic logic [15:0] I_XOR_DUMMY();
      return 16'h0040;
   endfunction

endmodule
`default_nettype wire

// File: doc/alu_rglr_pipe.md
# alu_rglr_pipe

Registered, self-contained successor to the regular-ALU stage: it decodes the 16-bit ALU info bus, selects operands, and computes the result with its own datapath instead of requesting the shared one. The result lands in a one-deep output register behind a valid/ready handshake, together with a pass-through tag and a write-back enable. It sits between dispatch and the write-back/commit arbiter and is parametrised in data width, PC width and tag width.

## Interface

- XLEN, 32, data width; power of two, ≥ 8
- PC_SIZE, 32, PC width; ≤ XLEN
- TAG_W, 5, width of the opaque tag carried alongside the op (rd index)
- SHAMT_W, $clog2(XLEN), derived; do not override
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- alu_i_valid  in  1  request valid
- alu_i_ready  out  1  request ready
- alu_i_rs1 / alu_i_rs2 / alu_i_imm  in  XLEN each  operands
- alu_i_pc  in  PC_SIZE  instruction PC
- alu_i_info  in  16  decode info: bit 2 ADD, 3 SUB, 4 SLT, 5 SLTU, 6 XOR, 7 OR, 8 AND, 9 SLL, 10 SRL, 11 SRA, 12 LUI, 13 OP2IMM, 14 OP1PC, 15 NOP; bits 1:0 ignored
- alu_i_tag  in  TAG_W  tag
- alu_o_valid  out  1  result valid
- alu_o_ready  in  1  result ready
- alu_o_wbck_wdat  out  XLEN  result
- alu_o_wbck_en  out  1  write result to register file
- alu_o_tag  out  TAG_W  tag of the result

## Operation

- Transfer in: alu_i_valid & alu_i_ready. Transfer out: alu_o_valid & alu_o_ready.
- op1 = OP1PC ? zero-extended alu_i_pc : rs1; op2 = OP2IMM ? imm : rs2.
- ADD/SUB: op1 ± op2 modulo 2^XLEN. SLT: signed op1 < op2 → 1, else 0. SLTU: unsigned compare. XOR/OR/AND: bitwise. SLL/SRL/SRA: op1 shifted by op2[SHAMT_W-1:0]; SRA sign-fills. LUI: result = op2.
- Op bits are one-hot by decoder contract; if several are set, the lowest-numbered bit wins.
- NOP set, or no op bit 2–12 set: result 0, wbck_en 0. Otherwise wbck_en 1.
- Output register {valid, wdat, wbck_en, tag} loads on every input transfer (single-cycle path). It holds stable while alu_o_valid & ~alu_o_ready.
- alu_i_ready = ~rst & (state == IDLE) & (~alu_o_valid | alu_o_ready).
- alu_o_valid clears on an output transfer with no simultaneous load; a simultaneous output transfer and load keeps valid at 1 with new data.

## Timing

- Reset (sync, one clk edge): alu_o_valid 0, alu_o_wbck_wdat 0, alu_o_wbck_en 0, alu_o_tag 0, state IDLE, internal shift counter 0.
- alu_i_ready is 0 while rst is high, and 1 on the first cycle after rst falls.
- Single-cycle ops: accepted at edge T; alu_o_valid is 1 during cycle T+1. Throughput is 1 op per cycle with alu_o_ready held high.
- alu_o_ready → alu_i_ready is a combinational path. No other combinational input-to-output path exists.
- Reset during any state aborts the in-flight op. No output is produced for it.

## Configuration

- SHIFT_ITER_EN undefined: shifts use a single-cycle barrel shifter, with latency identical to other ops.
- SHIFT_ITER_EN defined: shifts use a 1-bit-per-cycle iterative shifter. FSM states IDLE, SHIFT, DONE.
  - IDLE → SHIFT on acceptance of a shift with shamt ≠ 0. This loads the work register with op1, the counter with shamt, and latches the tag.
  - Shift with shamt = 0 follows the single-cycle path.
  - SHIFT: shift work register by 1 per cycle and decrement the counter. At counter 1→0, go to DONE.
  - DONE: when ~alu_o_valid | alu_o_ready, load the output register and go to IDLE. Otherwise stay in DONE.
  - alu_i_ready is 0 in SHIFT and DONE.
  - Latency, accept to alu_o_valid: shamt+2 cycles with no backpressure.

## Test plan

- ADD rs1=0x7FFFFFFF, rs2=1 → next cycle: wdat 0x80000000, wbck_en 1, tag echoed. SUB 0 − 1 → 0xFFFFFFFF.
- SLT rs1=0xFFFFFFFF, rs2=1 → 1. SLTU with the same operands → 0. OP1PC+OP2IMM ADD with pc=0x1000, imm=0x2000 → 0x3000. LUI imm=0xABCDE000 → 0xABCDE000.
- NOP bit with ADD bit set → valid 1, wbck_en 0, wdat 0. Info with no op bit set → same response.
- Back-to-back ADDs with tags 1 and 2, alu_o_ready low for 3 cycles → tag-1 result held stable, alu_i_ready 0. Tag 2 is accepted in the cycle alu_o_ready rises. Both results are delivered in order; none lost or duplicated.
- SRA rs1=0x80000000, OP2IMM, imm=4 → 0xF8000000.
  - Without SHIFT_ITER_EN: valid 1 cycle after accept.
  - With SHIFT_ITER_EN: valid 6 cycles after accept, alu_i_ready 0 throughout.
  - SLL shamt 0 with SHIFT_ITER_EN → 1-cycle latency.
- With SHIFT_ITER_EN, SLL shamt 31 in flight, rst pulsed at cycle 5 → all outputs 0 the next cycle, no result ever emitted, alu_i_ready 1 after rst falls.
